regular_pa_dsa_xocc_agent: RTL and testbench
============================================

Name: regular_pa_dsa_xocc_agent

Overview:
DSA-side endpoint of the XOCC command/response queue pair, one instance per queue.
- Consumes commands from a first-word-fall-through (FWFT) command FIFO: observes `empty_cmd`, pops with a `rd_en_cmd` pulse.
- Issues each command to a DSA compute engine over a valid/ready request channel, then waits for the engine's result.
- Pushes one 32-bit response word into the response FIFO, gated by `full_rsp`.
- Sits between the CPU-side XOCC unit's FIFOs and the accelerator datapath.

Parameters:
- CMD_WIDTH, 96, width of one command entry; must be a multiple of 32 and at least 96.
- RSP_WIDTH, 32, width of one response entry; fixed at 32.
- TIMEOUT_CYCLES, 1024, number of WAIT-state cycles before the agent gives up on the engine; must be at least 2.
- TO_RSP_WORD, 32'hFFFF_FFFF, response word pushed when a timeout occurs.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous, active-low reset
- dsa_cmd_buffer  in  CMD_WIDTH  FWFT head of the command FIFO; valid when empty_cmd=0
- empty_cmd  in  1  command FIFO empty
- rd_en_cmd  out  1  pop pulse to the command FIFO
- dsa_rsp_buffer  out  RSP_WIDTH  response write data
- full_rsp  in  1  response FIFO full
- wr_en_rsp  out  1  push pulse to the response FIFO
- eng_req_vld  out  1  request valid to the engine
- eng_req_rdy  in  1  engine accepts the request
- eng_req_op  out  8  opcode, taken from cmd[7:0]
- eng_req_tag  out  8  tag, taken from cmd[15:8]
- eng_req_opa  out  32  operand A, taken from cmd[63:32]
- eng_req_opb  out  32  operand B, taken from cmd[95:64]
- eng_rsp_vld  in  1  single-cycle result strobe from the engine
- eng_rsp_data  in  32  result data, sampled when eng_rsp_vld=1
- agent_busy  out  1  1 whenever the state is not IDLE
- err_timeout  out  1  sticky timeout flag
- cmd_done_cnt  out  16  count of completed commands; wraps

Behaviour:
- Reset (async, cpurst_b=0):
  - state=IDLE.
  - All registered outputs are 0: dsa_rsp_buffer, eng_req_*, err_timeout, cmd_done_cnt, and the timeout counter.
  - rd_en_cmd=0 and wr_en_rsp=0.
  - Reset asserted mid-operation abandons the command in flight; no response is pushed for it.
- State machine, 4 states:
  - IDLE: rd_en_cmd = ~empty_cmd (combinational). When empty_cmd=0:
    - latch dsa_cmd_buffer into the command register in the same cycle as the pop;
    - go to ISSUE.
    - rd_en_cmd is 0 in every other state.
  - ISSUE: eng_req_vld=1 with fields driven from the latched command. Fields are stable while vld=1 and rdy=0. When eng_req_rdy=1, clear eng_req_vld next cycle, clear the timeout counter, and go to WAIT.
  - WAIT: the timeout counter increments each cycle.
    - On eng_rsp_vld=1: latch eng_rsp_data into dsa_rsp_buffer; go to RESP.
    - Else, when counter = TIMEOUT_CYCLES-1: load TO_RSP_WORD into dsa_rsp_buffer, set err_timeout, go to RESP.
    - If eng_rsp_vld and the timeout terminal count occur in the same cycle, the engine result wins and err_timeout is not set.
  - RESP: wr_en_rsp = ~full_rsp (combinational). On ~full_rsp: increment cmd_done_cnt (wraps from 16'hFFFF to 0) and go to IDLE. While full_rsp=1, hold the state and hold dsa_rsp_buffer stable.
- Pops and pushes:
  - Exactly one rd_en_cmd pulse per command and exactly one wr_en_rsp pulse per command.
  - A pop never occurs while empty_cmd=1; a push never occurs while full_rsp=1.
- eng_rsp_vld outside WAIT is ignored.
- Latency: with a zero-latency engine (rdy=1 in ISSUE, rsp_vld in the first WAIT cycle), the wr_en_rsp pulse comes 3 cycles after the rd_en_cmd pulse. Minimum 4 cycles per command.
- err_timeout clears only on reset.
- agent_busy is a registered decode of state≠IDLE.

Decomposition:
- Shared package regular_pa_xocc_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - command field offsets (OP_LSB=0, TAG_LSB=8, OPA_LSB=32, OPB_LSB=64);
  - TO_RSP_WORD default.
- One sub-module, regular_pa_xocc_to_cnt: a loadable timeout counter with clear, enable and terminal-count output.
- FSM and datapath stay in the top module.

Test Plan:
1. Single command, OPA=32'h5 and OPB=32'h7, with an echo engine (rdy=1, result=opa+opb one cycle later) -> one rd_en_cmd pulse, one wr_en_rsp pulse with dsa_rsp_buffer=32'hC, cmd_done_cnt=1, err_timeout=0.
2. Back-to-back: 3 commands queued, zero-latency engine -> 3 pops and 3 pushes, each command taking exactly 4 cycles, responses in order, cmd_done_cnt=3.
3. Backpressure on both sides:
   - eng_req_rdy held 0 for 10 cycles -> eng_req_vld and all fields stable throughout;
   - then full_rsp held 1 for 5 cycles in RESP -> no wr_en_rsp, data stable, push happens on the cycle full_rsp drops.
4. Timeout: engine never responds, TIMEOUT_CYCLES=16 -> push of 32'hFFFF_FFFF 16 cycles after entering WAIT, err_timeout=1 and sticky across later good commands.
5. Tie: eng_rsp_vld coincides with the terminal count -> engine data is pushed, err_timeout stays 0.
6. Reset mid-WAIT: cpurst_b pulsed low -> all outputs 0, state IDLE, no push; the next queued command processes normally.

Source files
------------

// File: rtl/regular_pa_dsa_xocc_agent_pkg.sv
// ---------------------------------------------------------------------------
// regular_pa_xocc_pkg
// Shared definitions for the DSA-side XOCC agent: FSM state encoding,
// command field layout and the default timeout response word.
// ---------------------------------------------------------------------------
package regular_pa_xocc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } xocc_state_t;

    // Command entry layout (bit offsets into the command word)
    localparam int unsigned OP_LSB  = 0;
    localparam int unsigned TAG_LSB = 8;
    localparam int unsigned OPA_LSB = 32;
    localparam int unsigned OPB_LSB = 64;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned OPND_W = 32;

    localparam logic [31:0] TO_RSP_WORD_DEF = 32'hFFFF_FFFF;

    // Counter width able to hold 0 .. cycles-1
    function automatic int unsigned to_cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/regular_pa_dsa_xocc_agent_if.sv
// ---------------------------------------------------------------------------
// regular_pa_dsa_xocc_agent_if
// Agent <-> DSA compute engine channel.
//   request : eng_req_vld / eng_req_rdy handshake carrying op, tag, opa, opb
//   result  : eng_rsp_vld single-cycle strobe with eng_rsp_data
// Modports: master = agent side, slave = engine side.
// ---------------------------------------------------------------------------
interface regular_pa_dsa_xocc_agent_if;
    import regular_pa_xocc_pkg::*;

    logic              eng_req_vld;
    logic              eng_req_rdy;
    logic [OP_W-1:0]   eng_req_op;
    logic [TAG_W-1:0]  eng_req_tag;
    logic [OPND_W-1:0] eng_req_opa;
    logic [OPND_W-1:0] eng_req_opb;
    logic              eng_rsp_vld;
    logic [31:0]       eng_rsp_data;

    modport master (
        output eng_req_vld, eng_req_op, eng_req_tag, eng_req_opa, eng_req_opb,
        input  eng_req_rdy, eng_rsp_vld, eng_rsp_data
    );

    modport slave (
        input  eng_req_vld, eng_req_op, eng_req_tag, eng_req_opa, eng_req_opb,
        output eng_req_rdy, eng_rsp_vld, eng_rsp_data
    );

endinterface

// File: rtl/regular_pa_dsa_xocc_agent_to_cnt.sv
// ---------------------------------------------------------------------------
// regular_pa_xocc_to_cnt
// Loadable up-counter used as the engine-response timeout.
//   forever_cpuclk, cpurst_b : clock, async active-low reset
//   clr      : synchronous clear (highest priority)
//   load     : load load_val
//   en       : increment
//   cnt      : current count
//   tc       : terminal count, cnt == TC_VALUE
// ---------------------------------------------------------------------------
module regular_pa_xocc_to_cnt #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned TC_VALUE = 1023
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TC_V = WIDTH'(TC_VALUE);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_V);

endmodule

// File: rtl/regular_pa_dsa_xocc_agent.sv
// ---------------------------------------------------------------------------
// regular_pa_dsa_xocc_agent
// DSA-side endpoint of one XOCC command/response queue pair. Pops a command
// from the FWFT command FIFO, issues it to the compute engine, waits for the
// result (or times out) and pushes one response word.
// Ports:
//   forever_cpuclk, cpurst_b : clock, async active-low reset
//   dsa_cmd_buffer, empty_cmd, rd_en_cmd : command FIFO head / empty / pop
//   dsa_rsp_buffer, full_rsp, wr_en_rsp  : response data / full / push
//   eng                     : engine request/result channel (master)
//   agent_busy              : state != IDLE (registered)
//   err_timeout             : sticky, set when the engine timed out
//   cmd_done_cnt            : completed command count, wraps
// ---------------------------------------------------------------------------
module regular_pa_dsa_xocc_agent
    import regular_pa_xocc_pkg::*;
#(
    parameter int unsigned          CMD_WIDTH      = 96,
    parameter int unsigned          RSP_WIDTH      = 32,
    parameter int unsigned          TIMEOUT_CYCLES = 1024,
    parameter logic [RSP_WIDTH-1:0] TO_RSP_WORD    = TO_RSP_WORD_DEF
) (
    input  logic                        forever_cpuclk,
    input  logic                        cpurst_b,
    input  logic [CMD_WIDTH-1:0]        dsa_cmd_buffer,
    input  logic                        empty_cmd,
    output logic                        rd_en_cmd,
    output logic [RSP_WIDTH-1:0]        dsa_rsp_buffer,
    input  logic                        full_rsp,
    output logic                        wr_en_rsp,
    regular_pa_dsa_xocc_agent_if.master eng,
    output logic                        agent_busy,
    output logic                        err_timeout,
    output logic [15:0]                 cmd_done_cnt
);

    localparam int unsigned TO_W = to_cnt_width(TIMEOUT_CYCLES);

    xocc_state_t     state;
    xocc_state_t     state_nxt;
    logic            to_clr;
    logic            to_en;
    logic            to_tc;
    logic [TO_W-1:0] to_cnt;

    // Bits of the command word outside the decoded fields are don't-care
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^dsa_cmd_buffer;

    regular_pa_xocc_to_cnt #(
        .WIDTH    (TO_W),
        .TC_VALUE (TIMEOUT_CYCLES - 1)
    ) u_to_cnt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .clr            (to_clr),
        .en             (to_en),
        .load           (1'b0),
        .load_val       ('0),
        .cnt            (to_cnt),
        .tc             (to_tc)
    );

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en_cmd = 1'b0;
        wr_en_rsp = 1'b0;
        to_clr    = 1'b0;
        to_en     = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so the FIFO is never popped while the
                // command register cannot capture the head entry.
                if (!empty_cmd && cpurst_b) begin
                    rd_en_cmd = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (eng.eng_req_rdy) begin
                    to_clr    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                to_en = 1'b1;
                if (eng.eng_rsp_vld || to_tc) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (!full_rsp) begin
                    wr_en_rsp = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The engine request fields double as the latched command register.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            eng.eng_req_vld <= 1'b0;
            eng.eng_req_op  <= '0;
            eng.eng_req_tag <= '0;
            eng.eng_req_opa <= '0;
            eng.eng_req_opb <= '0;
            dsa_rsp_buffer  <= '0;
            err_timeout     <= 1'b0;
            cmd_done_cnt    <= '0;
            agent_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en_cmd) begin
                        eng.eng_req_vld <= 1'b1;
                        eng.eng_req_op  <= dsa_cmd_buffer[OP_LSB  +: OP_W];
                        eng.eng_req_tag <= dsa_cmd_buffer[TAG_LSB +: TAG_W];
                        eng.eng_req_opa <= dsa_cmd_buffer[OPA_LSB +: OPND_W];
                        eng.eng_req_opb <= dsa_cmd_buffer[OPB_LSB +: OPND_W];
                    end
                end
                ISSUE: begin
                    if (eng.eng_req_rdy) begin
                        eng.eng_req_vld <= 1'b0;
                    end
                end
                WAIT: begin
                    // Engine result takes priority over a coincident timeout
                    if (eng.eng_rsp_vld) begin
                        dsa_rsp_buffer <= eng.eng_rsp_data;
                    end else if (to_tc) begin
                        dsa_rsp_buffer <= TO_RSP_WORD;
                        err_timeout    <= 1'b1;
                    end
                end
                RESP: begin
                    if (wr_en_rsp) begin
                        cmd_done_cnt <= cmd_done_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
            // Decoding the next state keeps agent_busy aligned with state
            agent_busy <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_regular_pa_dsa_xocc_agent.sv
module tb_regular_pa_dsa_xocc_agent;
    import regular_pa_xocc_pkg::*;

    localparam int unsigned TO_CYC = 16;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst_b       = 1'b0;
    logic [95:0] dsa_cmd_buffer;
    logic        empty_cmd;
    logic        rd_en_cmd;
    logic [31:0] dsa_rsp_buffer;
    logic        full_rsp;
    logic        wr_en_rsp;
    logic        agent_busy;
    logic        err_timeout;
    logic [15:0] cmd_done_cnt;

    regular_pa_dsa_xocc_agent_if eng_if();

    regular_pa_dsa_xocc_agent #(
        .CMD_WIDTH      (96),
        .RSP_WIDTH      (32),
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_RSP_WORD    (32'hFFFF_FFFF)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .dsa_cmd_buffer (dsa_cmd_buffer),
        .empty_cmd      (empty_cmd),
        .rd_en_cmd      (rd_en_cmd),
        .dsa_rsp_buffer (dsa_rsp_buffer),
        .full_rsp       (full_rsp),
        .wr_en_rsp      (wr_en_rsp),
        .eng            (eng_if),
        .agent_busy     (agent_busy),
        .err_timeout    (err_timeout),
        .cmd_done_cnt   (cmd_done_cnt)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    logic [95:0] fifo[$];
    logic [31:0] sb[$];
    int          pop_cyc[$];
    int          pop_times[$];
    logic [95:0] cur_cmd = '0;
    int          exp_lat = 3;
    int          n_pop   = 0;
    int          n_push  = 0;
    int          eng_lat = 1;
    int          eng_rdy_delay = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    // Queue a command and its expected response; call only at posedge+1
    task automatic send(input logic [7:0] op, input logic [7:0] tag,
                        input logic [31:0] opa, input logic [31:0] opb,
                        input logic [31:0] exp_rsp);
        fifo.push_back({opb, opa, 16'hA5A5, tag, op});
        sb.push_back(exp_rsp);
        empty_cmd      = 1'b0;
        dsa_cmd_buffer = fifo[0];
    endtask

    task automatic wait_idle(input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (!done && n < budget) begin
            @(negedge forever_cpuclk);
            n++;
            done = (fifo.size() == 0) && (sb.size() == 0) && !agent_busy;
        end
        check("idle_within_budget", 64'(done), 64'd1);
        tick();
    endtask

    // Command FIFO model + response scoreboard + request field monitor
    initial begin : fifo_mon
        logic        rd;
        logic [31:0] e;
        int          pc;
        forever begin
            @(negedge forever_cpuclk);
            rd = rd_en_cmd;
            if (rd) begin
                check("pop_while_empty", 64'(empty_cmd), 64'd0);
                cur_cmd = dsa_cmd_buffer;
                pop_cyc.push_back(cyc);
                pop_times.push_back(cyc);
                n_pop++;
            end
            if (eng_if.eng_req_vld) begin
                check("req_op",  64'(eng_if.eng_req_op),  64'(cur_cmd[7:0]));
                check("req_tag", 64'(eng_if.eng_req_tag), 64'(cur_cmd[15:8]));
                check("req_opa", 64'(eng_if.eng_req_opa), 64'(cur_cmd[63:32]));
                check("req_opb", 64'(eng_if.eng_req_opb), 64'(cur_cmd[95:64]));
            end
            if (wr_en_rsp) begin
                n_push++;
                check("push_while_full", 64'(full_rsp), 64'd0);
                check("push_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rsp_data", 64'(dsa_rsp_buffer), 64'(e));
                end
                if (pop_cyc.size() > 0) begin
                    pc = pop_cyc.pop_front();
                    check("pop_to_push_latency", 64'(cyc - pc), 64'(exp_lat));
                end
            end
            tick();
            if (rd && fifo.size() > 0) void'(fifo.pop_front());
            empty_cmd = (fifo.size() == 0);
            if (fifo.size() > 0) dsa_cmd_buffer = fifo[0];
        end
    end

    // Engine model: rdy after eng_rdy_delay ISSUE cycles, result = opa+opb
    // in WAIT cycle eng_lat (0 = never responds)
    initial begin : eng_model
        logic        acc;
        logic [31:0] a, b, res;
        int          cd, hold;
        cd = 0; hold = 0; res = '0;
        eng_if.eng_req_rdy  = 1'b0;
        eng_if.eng_rsp_vld  = 1'b0;
        eng_if.eng_rsp_data = '0;
        forever begin
            @(negedge forever_cpuclk);
            acc = eng_if.eng_req_vld && eng_if.eng_req_rdy;
            a   = eng_if.eng_req_opa;
            b   = eng_if.eng_req_opb;
            tick();
            eng_if.eng_rsp_vld = 1'b0;
            if (!cpurst_b) cd = 0;
            if (acc) begin
                cd  = eng_lat;
                res = a + b;
            end
            if (cd == 1) begin
                eng_if.eng_rsp_vld  = 1'b1;
                eng_if.eng_rsp_data = res;
            end
            if (cd > 0) cd--;
            if (eng_if.eng_req_vld) begin
                if (hold >= eng_rdy_delay) begin
                    eng_if.eng_req_rdy = 1'b1;
                end else begin
                    eng_if.eng_req_rdy = 1'b0;
                    hold++;
                end
            end else begin
                eng_if.eng_req_rdy = 1'b0;
                hold = 0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        int pushes_before;
        empty_cmd      = 1'b1;
        dsa_cmd_buffer = '0;
        full_rsp       = 1'b0;
        cpurst_b       = 1'b0;

        // Reset state
        repeat (2) @(negedge forever_cpuclk);
        check("rst_busy",    64'(agent_busy),         64'd0);
        check("rst_vld",     64'(eng_if.eng_req_vld), 64'd0);
        check("rst_rsp_buf", 64'(dsa_rsp_buffer),     64'd0);
        check("rst_err",     64'(err_timeout),        64'd0);
        check("rst_cnt",     64'(cmd_done_cnt),       64'd0);
        check("rst_wr_en",   64'(wr_en_rsp),          64'd0);
        tick();
        cpurst_b = 1'b1;
        tick();

        // 1: single command, echo engine
        eng_lat = 1; eng_rdy_delay = 0; exp_lat = 3;
        send(8'h01, 8'h10, 32'h5, 32'h7, 32'hC);
        wait_idle(100);
        check("t1_cnt",  64'(cmd_done_cnt), 64'd1);
        check("t1_err",  64'(err_timeout),  64'd0);
        check("t1_pops", 64'(n_pop),        64'd1);
        check("t1_push", 64'(n_push),       64'd1);

        // 2: three back-to-back commands, four cycles each
        pop_times.delete();
        send(8'h02, 8'h21, 32'h1000_0000, 32'h0000_0001, 32'h1000_0001);
        send(8'h03, 8'h22, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        send(8'h04, 8'h23, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
        wait_idle(100);
        check("t2_npop", 64'(pop_times.size()), 64'd3);
        if (pop_times.size() == 3) begin
            check("t2_gap0", 64'(pop_times[1] - pop_times[0]), 64'd4);
            check("t2_gap1", 64'(pop_times[2] - pop_times[1]), 64'd4);
        end
        check("t2_cnt",  64'(cmd_done_cnt), 64'd4);
        check("t2_push", 64'(n_push),       64'd4);

        // 3: request held off 10 cycles, then response FIFO full for 5
        eng_rdy_delay = 10; full_rsp = 1'b1; exp_lat = 3 + 10 + 5;
        send(8'h05, 8'h33, 32'hDEAD_0000, 32'h0000_BEEF, 32'hDEAD_BEEF);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge forever_cpuclk);
            seen = eng_if.eng_req_vld;
        end
        check("t3_vld_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("t3_vld_hold", 64'(eng_if.eng_req_vld), 64'd1);
            check("t3_rdy_low",  64'(eng_if.eng_req_rdy), 64'd0);
            @(negedge forever_cpuclk);
        end
        seen = eng_if.eng_rsp_vld;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge forever_cpuclk);
            seen = eng_if.eng_rsp_vld;
        end
        check("t3_rsp_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge forever_cpuclk);
            check("t3_no_push_full", 64'(wr_en_rsp),      64'd0);
            check("t3_buf_stable",   64'(dsa_rsp_buffer), 64'hDEAD_BEEF);
        end
        tick();
        full_rsp = 1'b0;
        wait_idle(100);
        eng_rdy_delay = 0;
        check("t3_cnt", 64'(cmd_done_cnt), 64'd5);

        // 5: result arrives on the timeout terminal-count cycle
        eng_lat = TO_CYC; exp_lat = 3 + TO_CYC - 1;
        send(8'h06, 8'h44, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB);
        wait_idle(100);
        check("t5_err", 64'(err_timeout),  64'd0);
        check("t5_cnt", 64'(cmd_done_cnt), 64'd6);

        // 4: engine never responds -> timeout word, sticky error
        eng_lat = 0; exp_lat = 3 + TO_CYC - 1;
        send(8'h07, 8'h55, 32'h1, 32'h2, 32'hFFFF_FFFF);
        wait_idle(100);
        check("t4_err", 64'(err_timeout),  64'd1);
        check("t4_cnt", 64'(cmd_done_cnt), 64'd7);
        eng_lat = 1; exp_lat = 3;
        send(8'h08, 8'h66, 32'h40, 32'h2, 32'h42);
        wait_idle(100);
        check("t4_err_sticky", 64'(err_timeout),  64'd1);
        check("t4_cnt_after",  64'(cmd_done_cnt), 64'd8);

        // 6: reset while waiting on the engine
        eng_lat = 0;
        send(8'h09, 8'h77, 32'h3, 32'h4, 32'h0);
        repeat (6) tick();
        check("t6_in_flight", 64'(agent_busy), 64'd1);
        pushes_before = n_push;
        cpurst_b = 1'b0;
        sb.delete();
        pop_cyc.delete();
        eng_lat = 1; exp_lat = 3;
        send(8'h0A, 8'h88, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123);
        @(negedge forever_cpuclk);
        check("t6_rst_busy",  64'(agent_busy),         64'd0);
        check("t6_rst_vld",   64'(eng_if.eng_req_vld), 64'd0);
        check("t6_rst_op",    64'(eng_if.eng_req_op),  64'd0);
        check("t6_rst_opa",   64'(eng_if.eng_req_opa), 64'd0);
        check("t6_rst_buf",   64'(dsa_rsp_buffer),     64'd0);
        check("t6_rst_err",   64'(err_timeout),        64'd0);
        check("t6_rst_cnt",   64'(cmd_done_cnt),       64'd0);
        check("t6_rst_rd_en", 64'(rd_en_cmd),          64'd0);
        check("t6_rst_wr_en", 64'(wr_en_rsp),          64'd0);
        tick();
        cpurst_b = 1'b1;
        wait_idle(100);
        check("t6_push_count", 64'(n_push - pushes_before), 64'd1);
        check("t6_cnt",        64'(cmd_done_cnt),           64'd1);
        check("t6_err",        64'(err_timeout),            64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
